// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Grants one of NUM_PORTS requesters ownership of a single memory port.
//   The owner keeps the port until it drops its request; a new owner is
//   picked round-robin, starting after the previous owner, in the same
//   cycle the old owner lets go, so there is never a dead cycle between
//   owners. Read data comes back one cycle after the access and is
//   captured in a per-port hold register so each port keeps seeing its
//   own last read result while other ports use the memory.
//
//   Optional feature: define MEM_ARB_QUOTA_EN to preempt an owner after
//   QUOTA consecutive owned cycles when another port is requesting.
//
// Ports
//   clk_i        clock, all state on the rising edge
//   reset_n_i    asynchronous active-low reset
//   req_i        per-port ownership request
//   en_i         per-port memory enable (honoured only for the owner)
//   addr_i       per-port address, port i in slice i
//   wben_i       per-port byte write enables, all-zero means read
//   wdata_i      per-port write data
//   rdata_o      per-port read data
//   stall_o      per-port stall, port must not assert en_i while high
//   mem_*_o      memory-side request (owner's slices, zero when idle)
//   mem_rdata_i  memory read data, one cycle after the access
//   mem_stall_i  memory back-pressure
//   grant_o      one-hot registered owner, zero when idle
//   error_o      saturating count of enables issued by non-owner ports
//
// state | meaning
// IDLE  | no owner, all ports stalled
// OWNED | owner register holds the granted port index
module mem_port_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int QUOTA      = 16
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [NUM_PORTS-1:0]               req_i,
  input  logic [NUM_PORTS-1:0]               en_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]  wben_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    wdata_i,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]    rdata_o,
  output logic [NUM_PORTS-1:0]               stall_o,
  output logic                               mem_en_o,
  output logic [ADDR_WIDTH-1:0]              mem_addr_o,
  output logic [DATA_WIDTH/8-1:0]            mem_wben_o,
  output logic [DATA_WIDTH-1:0]              mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]              mem_rdata_i,
  input  logic                               mem_stall_i,
  output logic [NUM_PORTS-1:0]               grant_o,
  output logic [31:0]                        error_o
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int IDX_WIDTH = $clog2(NUM_PORTS);
  localparam int SUM_WIDTH = IDX_WIDTH + 1;
  localparam int CNT_WIDTH = $clog2(NUM_PORTS + 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state, state_nxt;
  logic [IDX_WIDTH-1:0]   owner, owner_nxt;
  logic [NUM_PORTS-1:0]   cand;
  logic [IDX_WIDTH-1:0]   pick;
  logic                   pick_vld;
  logic [SUM_WIDTH-1:0]   rr_sum;
  logic [IDX_WIDTH-1:0]   rr_idx;
  logic                   change;
  logic                   quota_hit;
  logic [NUM_PORTS-1:0]   acc, acc_d;
  logic [DATA_WIDTH-1:0]  hold [NUM_PORTS];
  logic [NUM_PORTS-1:0]   nonowner_en;
  logic [CNT_WIDTH-1:0]   err_inc;
  logic [32:0]            err_sum;

  // The owner register doubles as the round-robin pointer: it keeps the
  // last owner while idle, and resets to the top port so port 0 wins first.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state   <= IDLE;
      owner   <= IDX_WIDTH'(NUM_PORTS - 1);
      grant_o <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      grant_o <= '0;
      if (state_nxt == OWNED) grant_o[owner_nxt] <= 1'b1;
    end
  end

  // Round-robin search starting after the current/last owner. The owner
  // itself is masked out, so while owned only other requesters compete.
  always_comb begin
    cand     = req_i & ~grant_o;
    pick     = owner;
    pick_vld = 1'b0;
    rr_sum   = '0;
    rr_idx   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      rr_sum = {1'b0, owner} + SUM_WIDTH'(k);
      if (rr_sum >= SUM_WIDTH'(NUM_PORTS)) rr_sum = rr_sum - SUM_WIDTH'(NUM_PORTS);
      rr_idx = rr_sum[IDX_WIDTH-1:0];
      if (!pick_vld && cand[rr_idx]) begin
        pick_vld = 1'b1;
        pick     = rr_idx;
      end
    end
  end

`ifdef MEM_ARB_QUOTA_EN
  localparam int QW = $clog2(QUOTA + 1);
  logic [QW-1:0] quota_cnt;

  // Down-counter loaded on every owner change; reaching zero means the
  // owner has held the port for QUOTA cycles. It parks at zero so a late
  // competing request preempts on the next edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)              quota_cnt <= '0;
    else if (change)             quota_cnt <= QW'(QUOTA - 1);
    else if (quota_cnt != '0)    quota_cnt <= quota_cnt - QW'(1);
  end

  assign quota_hit = (state == OWNED) && (quota_cnt == '0);
`else
  assign quota_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    change    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = OWNED;
          owner_nxt = pick;
          change    = 1'b1;
        end
      end
      OWNED: begin
        if (!req_i[owner] || quota_hit) begin
          if (pick_vld) begin
            owner_nxt = pick;
            change    = 1'b1;
          end else if (!req_i[owner]) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall_o     = '1;
    mem_en_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wben_o  = '0;
    mem_wdata_o = '0;
    acc         = '0;
    if (state == OWNED) begin
      stall_o[owner] = mem_stall_i;
      mem_en_o       = en_i[owner] & ~mem_stall_i;
      mem_addr_o     = addr_i[owner*ADDR_WIDTH +: ADDR_WIDTH];
      mem_wben_o     = wben_i[owner*BE_WIDTH +: BE_WIDTH];
      mem_wdata_o    = wdata_i[owner*DATA_WIDTH +: DATA_WIDTH];
      acc[owner]     = mem_en_o;
    end
  end

  // acc_d marks the port whose data is on mem_rdata_i this cycle; reset
  // clears it, which discards any read still in flight.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      acc_d <= '0;
      for (int p = 0; p < NUM_PORTS; p++) hold[p] <= '0;
    end else begin
      acc_d <= acc;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (acc_d[p]) hold[p] <= mem_rdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = acc_d[p] ? mem_rdata_i : hold[p];
    end
  end

  // grant_o is zero when idle, so every enable counts as a violation then.
  always_comb begin
    nonowner_en = en_i & ~grant_o;
    err_inc     = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      err_inc = err_inc + CNT_WIDTH'(nonowner_en[p]);
    end
    err_sum = {1'b0, error_o} + 33'(err_inc);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)      error_o <= '0;
    else if (err_sum[32]) error_o <= '1;
    else                 error_o <= err_sum[31:0];
  end

endmodule
